// File: rtl/csr_mtrap_unit_pkg.sv
// csr_mtrap_unit_pkg: CSR addresses, cause codes, bit positions and FSM state for the M-mode trap unit.
package csr_mtrap_unit_pkg;
    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam int BIT_MIE  = 3;
    localparam int BIT_MPIE = 7;
    localparam int BIT_MSIE = 3;
    localparam int BIT_MTIE = 7;
    localparam int BIT_MEIE = 11;
    localparam logic [1:0] MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MODE_VECTORED = 2'b01;
    typedef enum logic {IDLE, REDIR} state_t;
endpackage

// File: rtl/csr_mtrap_unit_counter.sv
// csr_counter: wrapping event counter with inhibit and CSR write override.
module csr_counter #(
    parameter int CNT_W = 64,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inhibit,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wdata,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk)
        cnt <= rst ? '0 : wr_en ? wdata : inhibit ? cnt : cnt + CNT_W'(inc);
endmodule

// File: rtl/csr_mtrap_unit.sv
// csr_mtrap_unit: M-mode CSR file, counters and trap/mret redirect sequencer beside commit.
module csr_mtrap_unit
    import csr_mtrap_unit_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int CNT_W    = 64,
    parameter int RETIRE_W = 2,
    parameter bit VECTORED = 1'b1,
    parameter int HART_ID  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           commit_valid,
    input  logic [XLEN-1:0]                pc_i,
    input  logic [$clog2(RETIRE_W+1)-1:0]  retire_cnt,
    input  logic                           csr_rd_en,
    input  logic                           csr_wr_en,
    input  logic [11:0]                    csr_idx,
    input  logic [XLEN-1:0]                csr_wdata,
    output logic [XLEN-1:0]                csr_rdata,
    output logic                           csr_illegal,
    input  logic                           exc_ena,
    input  logic [XLEN-1:0]                exc_cause,
    input  logic [XLEN-1:0]                exc_tval,
    input  logic                           mret_ena,
    input  logic                           irq_sw,
    input  logic                           irq_tmr,
    input  logic                           irq_ext,
    output logic                           redirect_valid,
    output logic [XLEN-1:0]                redirect_pc,
    output logic                           redirect_is_trap
);
    localparam int RC_W = $clog2(RETIRE_W+1);
    state_t state, state_nxt;
    logic mie_q, mpie_q, cy_inh, ir_inh;
    logic [2:0] ie_q, ip_q, pend;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [CNT_W-1:0] mcycle, minstret;
    logic idle, irq_take, trap, mret_take, wr, implemented;
    logic [3:0] irq_cause;
    logic [XLEN-1:0] rd_val, trap_base, trap_pc;
    // interrupt vectors are packed {ext, tmr, sw}
    assign idle      = state == IDLE;
    assign pend      = ip_q & ie_q;
    assign irq_cause = pend[2] ? CAUSE_MEI : pend[0] ? CAUSE_MSI : CAUSE_MTI;
    assign irq_take  = idle & commit_valid & mie_q & |pend;
    assign trap      = idle & (exc_ena | irq_take);
    assign mret_take = idle & mret_ena & ~trap;
    assign wr        = csr_wr_en & ~trap & ~csr_illegal;
    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_pc   = (!exc_ena && mtvec_q[1:0] == MODE_VECTORED) ? trap_base + XLEN'({irq_cause, 2'b00}) : trap_base;
    always_comb begin
        rd_val = '0;
        implemented = 1'b1;
        case (csr_idx)
            CSR_MSTATUS:       rd_val = XLEN'({2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0});
            CSR_MIE:           rd_val = XLEN'({ie_q[2], 3'b0, ie_q[1], 3'b0, ie_q[0], 3'b0});
            CSR_MIP:           rd_val = XLEN'({ip_q[2], 3'b0, ip_q[1], 3'b0, ip_q[0], 3'b0});
            CSR_MTVEC:         rd_val = mtvec_q;
            CSR_MCOUNTINHIBIT: rd_val = XLEN'({ir_inh, 1'b0, cy_inh});
            CSR_MSCRATCH:      rd_val = mscratch_q;
            CSR_MEPC:          rd_val = mepc_q;
            CSR_MCAUSE:        rd_val = mcause_q;
            CSR_MTVAL:         rd_val = mtval_q;
            CSR_MCYCLE:        rd_val = XLEN'(mcycle);
            CSR_MINSTRET:      rd_val = XLEN'(minstret);
            CSR_MVENDORID:     rd_val = '0;
            CSR_MHARTID:       rd_val = XLEN'(HART_ID);
            default:           implemented = 1'b0;
        endcase
    end
    assign csr_rdata   = csr_rd_en ? rd_val : '0;
    assign csr_illegal = (csr_rd_en | csr_wr_en) &
                         (~implemented | (csr_wr_en & (csr_idx == CSR_MVENDORID | csr_idx == CSR_MHARTID)));
    always_ff @(posedge clk) begin
        if (rst) begin
            {mie_q, mpie_q, cy_inh, ir_inh, ie_q, ip_q} <= '0;
            {mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q} <= '0;
            redirect_pc      <= '0;
            redirect_is_trap <= 1'b0;
        end else begin
            ip_q <= {irq_ext, irq_tmr, irq_sw};
            if (wr && csr_idx == CSR_MIE) ie_q <= {csr_wdata[BIT_MEIE], csr_wdata[BIT_MTIE], csr_wdata[BIT_MSIE]};
            if (wr && csr_idx == CSR_MTVEC)
                mtvec_q <= {csr_wdata[XLEN-1:2], (VECTORED && csr_wdata[1:0] == MODE_VECTORED) ? MODE_VECTORED : MODE_DIRECT};
            if (wr && csr_idx == CSR_MCOUNTINHIBIT) {ir_inh, cy_inh} <= {csr_wdata[2], csr_wdata[0]};
            if (wr && csr_idx == CSR_MSCRATCH) mscratch_q <= csr_wdata;
            mepc_q   <= trap ? pc_i & ~XLEN'(3) : (wr && csr_idx == CSR_MEPC) ? csr_wdata & ~XLEN'(3) : mepc_q;
            mcause_q <= trap ? (exc_ena ? exc_cause : {1'b1, (XLEN-1)'(irq_cause)}) :
                        (wr && csr_idx == CSR_MCAUSE) ? csr_wdata : mcause_q;
            mtval_q  <= trap ? (exc_ena ? exc_tval : '0) : (wr && csr_idx == CSR_MTVAL) ? csr_wdata : mtval_q;
            // mret's stack pop takes precedence over a concurrent mstatus write
            mie_q  <= trap ? 1'b0 : mret_take ? mpie_q : (wr && csr_idx == CSR_MSTATUS) ? csr_wdata[BIT_MIE] : mie_q;
            mpie_q <= trap ? mie_q : mret_take ? 1'b1 : (wr && csr_idx == CSR_MSTATUS) ? csr_wdata[BIT_MPIE] : mpie_q;
            if (trap || mret_take) begin
                redirect_pc      <= trap ? trap_pc : mepc_q;
                redirect_is_trap <= trap;
            end
        end
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt = (idle && (trap || mret_take)) ? REDIR : IDLE;
    end
    assign redirect_valid = state == REDIR;
    csr_counter #(.CNT_W(CNT_W), .INC_W(1)) u_mcycle (
        .clk(clk), .rst(rst), .inhibit(cy_inh), .wr_en(wr && csr_idx == CSR_MCYCLE),
        .wdata(csr_wdata[CNT_W-1:0]), .inc(1'b1), .cnt(mcycle)
    );
    csr_counter #(.CNT_W(CNT_W), .INC_W(RC_W)) u_minstret (
        .clk(clk), .rst(rst), .inhibit(ir_inh), .wr_en(wr && csr_idx == CSR_MINSTRET),
        .wdata(csr_wdata[CNT_W-1:0]), .inc(retire_cnt), .cnt(minstret)
    );
endmodule

// File: tb/tb_csr_mtrap_unit.sv
// tb_csr_mtrap_unit: randomized scoreboard bench against an architectural CSR/trap model.
module tb_csr_mtrap_unit;
    localparam int HART_ID = 3;
    logic clk = 0, rst = 1;
    logic commit_valid = 0, csr_rd_en = 0, csr_wr_en = 0, exc_ena = 0, mret_ena = 0;
    logic irq_sw = 0, irq_tmr = 0, irq_ext = 0;
    logic [63:0] pc_i = 0, csr_wdata = 0, exc_cause = 0, exc_tval = 0;
    logic [1:0] retire_cnt = 0;
    logic [11:0] csr_idx = 0;
    logic [63:0] csr_rdata, redirect_pc;
    logic csr_illegal, redirect_valid, redirect_is_trap;
    always #5 clk = ~clk;

    csr_mtrap_unit #(.XLEN(64), .CNT_W(64), .RETIRE_W(2), .VECTORED(1'b1), .HART_ID(HART_ID)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc_i(pc_i), .retire_cnt(retire_cnt),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .exc_ena(exc_ena), .exc_cause(exc_cause),
        .exc_tval(exc_tval), .mret_ena(mret_ena), .irq_sw(irq_sw), .irq_tmr(irq_tmr), .irq_ext(irq_ext),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_is_trap(redirect_is_trap)
    );

    typedef struct {logic [63:0] pc; logic trap; int cyc;} redir_t;
    typedef struct {logic [63:0] data; logic ill;} rd_t;
    redir_t rq[$];
    rd_t cq[$];
    int cyc = 0, nchk = 0, nfail = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    rd_t e;
    redir_t r;
    always @(negedge clk) begin
        if (csr_rd_en || csr_wr_en) begin
            if (cq.size() == 0) check("csr_expect_missing", 64'(cq.size()), 1);
            else begin
                e = cq.pop_front();
                check($sformatf("csr_rdata[%h]", csr_idx), csr_rdata, e.data);
                check($sformatf("csr_illegal[%h]", csr_idx), 64'(csr_illegal), 64'(e.ill));
            end
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            check("redirect_valid", 64'(redirect_valid), 1);
            check("redirect_pc", redirect_pc, r.pc);
            check("redirect_is_trap", 64'(redirect_is_trap), 64'(r.trap));
        end else check("redirect_quiet", 64'(redirect_valid), 0);
    end

    // Architectural model: a table of CSR values keyed by address; only implemented CSRs exist.
    logic [63:0] m [logic [11:0]];
    logic m_busy;

    task automatic model_reset();
        foreach (m[k]) m[k] = 0;
        m_busy = 0;
    endtask

    function automatic logic [63:0] rdv(logic [11:0] a);
        if (a == 12'h300) return m[a] | 64'h1800;
        if (a == 12'hF14) return 64'(HART_ID);
        return m[a];
    endfunction

    function automatic logic [63:0] legalize(logic [11:0] a, logic [63:0] v, logic [63:0] old);
        case (a)
            12'h300: return v & 64'h88;
            12'h304: return v & 64'h888;
            12'h305: return {v[63:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
            12'h320: return v & 64'h5;
            12'h341: return v & ~64'h3;
            12'h344, 12'hF11, 12'hF14: return old;
            default: return v;
        endcase
    endfunction

    task automatic step();
        logic [63:0] pend, base, tgt, inh, ms;
        logic ir_take, trap, mr, impl, legal;
        int cause;
        impl = m.exists(csr_idx);
        legal = impl && !(csr_wr_en && (csr_idx == 12'hF11 || csr_idx == 12'hF14));
        if (csr_rd_en || csr_wr_en) cq.push_back('{(csr_rd_en && impl) ? rdv(csr_idx) : 64'h0, !legal});
        if (rst) begin
            model_reset();
            @(posedge clk); #1;
            return;
        end
        ms = m[12'h300];
        pend = m[12'h344] & m[12'h304];
        ir_take = !m_busy && commit_valid && ms[3] && pend != 0;
        trap = !m_busy && (exc_ena || ir_take);
        cause = pend[11] ? 11 : pend[3] ? 3 : 7;
        mr = !m_busy && mret_ena && !trap;
        base = m[12'h305] & ~64'h3;
        tgt = (!exc_ena && m[12'h305][1:0] == 2'b01) ? base + 64'(4 * cause) : base;
        if (trap) rq.push_back('{tgt, 1'b1, cyc + 1});
        else if (mr) rq.push_back('{m[12'h341], 1'b0, cyc + 1});
        inh = m[12'h320];
        if (!inh[0]) m[12'hB00] = m[12'hB00] + 1;
        if (!inh[2]) m[12'hB02] = m[12'hB02] + 64'(retire_cnt);
        if (csr_wr_en && legal && !trap) m[csr_idx] = legalize(csr_idx, csr_wdata, m[csr_idx]);
        if (trap) begin
            m[12'h341] = pc_i & ~64'h3;
            m[12'h342] = exc_ena ? exc_cause : (64'h1 << 63) | 64'(cause);
            m[12'h343] = exc_ena ? exc_tval : 0;
            m[12'h300] = ms[3] ? 64'h80 : 64'h0;
        end else if (mr) m[12'h300] = 64'h80 | (ms[7] ? 64'h8 : 64'h0);
        m[12'h344] = (64'(irq_ext) << 11) | (64'(irq_tmr) << 7) | (64'(irq_sw) << 3);
        m_busy = trap || mr;
        @(posedge clk); #1;
    endtask

    task automatic quiet();
        {commit_valid, csr_rd_en, csr_wr_en, exc_ena, mret_ena} = '0;
        retire_cnt = 0;
    endtask

    task automatic wr_csr(logic [11:0] a, logic [63:0] v);
        csr_wr_en = 1; csr_idx = a; csr_wdata = v;
        step();
        csr_wr_en = 0;
    endtask

    task automatic rd_csr(logic [11:0] a);
        csr_rd_en = 1; csr_idx = a;
        step();
        csr_rd_en = 0;
    endtask

    logic [11:0] addrs [15] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF11, 12'hF14, 12'h7C0, 12'h123};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        foreach (addrs[i]) if (i < 13) m[addrs[i]] = 0;
        model_reset();
        @(posedge clk); #1;
        rst = 1; step(); step();
        rst = 0;
        rd_csr(12'h300);
        rd_csr(12'hF14);
        rd_csr(12'h7C0);
        wr_csr(12'hF11, 64'hDEAD);
        rd_csr(12'hF11);
        // vectored timer interrupt
        wr_csr(12'h305, 64'h8000_0001);
        wr_csr(12'h304, 64'h80);
        wr_csr(12'h300, 64'h8);
        commit_valid = 1; pc_i = 64'h8000_1000; irq_tmr = 1;
        step(); step();
        irq_tmr = 0; commit_valid = 0;
        step();
        rd_csr(12'h342); rd_csr(12'h341); rd_csr(12'h300);
        // exception beats a pending external interrupt, then mret
        wr_csr(12'h304, 64'h888); wr_csr(12'h300, 64'h8);
        irq_ext = 1; step();
        exc_ena = 1; exc_cause = 11; exc_tval = 64'h1234; commit_valid = 1; pc_i = 64'h8000_2004;
        step();
        exc_ena = 0; commit_valid = 0; irq_ext = 0;
        step();
        rd_csr(12'h342); rd_csr(12'h343);
        mret_ena = 1; step(); mret_ena = 0;
        step(); rd_csr(12'h300);
        // counters: retire, inhibit, wrap
        wr_csr(12'hB02, 0);
        retire_cnt = 2; repeat (5) step(); retire_cnt = 0;
        rd_csr(12'hB02);
        wr_csr(12'h320, 64'h4);
        retire_cnt = 2; rd_csr(12'hB02); rd_csr(12'hB00); rd_csr(12'hB02); retire_cnt = 0;
        wr_csr(12'h320, 0);
        wr_csr(12'hB00, '1);
        rd_csr(12'hB00); rd_csr(12'hB00);
        // back-to-back exceptions: second is swallowed by REDIR
        exc_ena = 1; exc_cause = 2; pc_i = 64'h100; step(); step(); exc_ena = 0;
        step(); step();
        // reset while REDIR, and reset coincident with acceptance
        exc_ena = 1; step(); exc_ena = 0; rst = 1; step(); rst = 0; step();
        exc_ena = 1; rst = 1; step(); exc_ena = 0; rst = 0; step(); step();
        rd_csr(12'h300);
        // randomized traffic
        repeat (400) begin
            commit_valid = $urandom_range(0, 3) != 0;
            pc_i = {$urandom, $urandom};
            retire_cnt = 2'($urandom_range(0, 2));
            csr_idx = addrs[$urandom_range(0, 14)];
            csr_rd_en = $urandom_range(0, 1) == 1;
            csr_wr_en = $urandom_range(0, 3) == 0;
            csr_wdata = $urandom_range(0, 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 15)) | 64'h888;
            if (csr_idx == 12'hB00 || csr_idx == 12'hB02) csr_wdata = $urandom_range(0, 1) ? '1 : 64'($urandom);
            exc_ena = $urandom_range(0, 9) == 0;
            exc_cause = 64'($urandom_range(0, 15));
            exc_tval = {$urandom, $urandom};
            mret_ena = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 7) == 0) irq_sw = ~irq_sw;
            if ($urandom_range(0, 7) == 0) irq_tmr = ~irq_tmr;
            if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
            step();
        end
        quiet();
        step(); step();
        check("redirect_queue_drained", 64'(rq.size()), 0);
        check("csr_queue_drained", 64'(cq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/csr_mtrap_unit.md
# csr_mtrap_unit

Parametrised machine-mode CSR file and trap sequencer for the superscalar core. It holds the M-mode CSRs, counts cycles and multi-wide retirement, and prioritises exceptions and three interrupt sources (software, timer, external). It issues a registered one-cycle PC redirect for trap entry (direct or vectored) and for `mret`. It sits beside the commit stage and is driven by the oldest committing instruction.

## Interface
- `XLEN`, 64: data and PC width.
- `CNT_W`, 64: implemented width of mcycle/minstret (≤ XLEN); zero-extended on read.
- `RETIRE_W`, 2: maximum instructions retired per cycle.
- `VECTORED`, 1: 1 allows mtvec mode 01; 0 hardwires mode to 00.
- `HART_ID`, 0: value read from mhartid.
---
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `commit_valid` in 1: a committing instruction exists this cycle; interrupts are taken only when set.
- `pc_i` in XLEN: PC of the oldest committing instruction.
- `retire_cnt` in $clog2(RETIRE_W+1): instructions retired this cycle.
- `csr_rd_en`, `csr_wr_en` in 1: CSR access strobes.
- `csr_idx` in 12: CSR address.
- `csr_wdata` in XLEN: final write value (the RW/RS/RC merge is done upstream).
- `csr_rdata` out XLEN: combinational read data; 0 when `csr_rd_en`=0.
- `csr_illegal` out 1: combinational; asserted for an unimplemented index, or a write to 0xF11/0xF14.
- `exc_ena` in 1: synchronous exception or ecall at `pc_i`.
- `exc_cause`, `exc_tval` in XLEN: mcause and mtval values for that exception.
- `mret_ena` in 1: committing `mret`.
- `irq_sw`, `irq_tmr`, `irq_ext` in 1: level interrupt requests.
- `redirect_valid` out 1: registered one-cycle redirect pulse; reset 0.
- `redirect_pc` out XLEN: registered target; reset 0.
- `redirect_is_trap` out 1: 1 for trap entry, 0 for mret; reset 0.

## Operation
- CSRs and write behaviour:
  - mstatus 0x300: MIE[3] and MPIE[7] are writable. MPP[12:11] is hardwired 11. All other bits read 0.
  - mie 0x304: bits 3/7/11 are writable.
  - mip 0x344: bits 3/7/11 are registered copies of `irq_sw`/`irq_tmr`/`irq_ext`. Writes are ignored and are not illegal.
  - mtvec 0x305: base is [63:2]. A mode write of 01 is kept only when `VECTORED`=1; every other mode value is stored as 00.
  - mscratch 0x340: fully writable.
  - mepc 0x341: bits [1:0] are forced to 0.
  - mcause 0x342 and mtval 0x343: fully writable.
  - mcountinhibit 0x320: only bits 0 (CY) and 2 (IR) are implemented.
  - mcycle 0xB00 and minstret 0xB02: described under counters below.
  - mvendorid 0xF11 reads 0; mhartid 0xF14 reads `HART_ID`.
- Counters:
  - mcycle increments by 1 per cycle unless CY is set.
  - minstret increments by `retire_cnt` unless IR is set.
  - Both wrap modulo 2^CNT_W.
  - A CSR write in the same cycle overrides the increment.
- Pending interrupts = mip & mie. An interrupt is taken when mstatus.MIE=1 and `commit_valid`=1.
- Trap priority, highest first: `exc_ena` > MEI (cause 11) > MSI (3) > MTI (7). Interrupt mcause = {1'b1, cause}.
- `mret_ena` is honoured only when no trap is accepted in that cycle.
- Trap acceptance (cycle T); updates at the T edge:
  - mepc ← `pc_i`.
  - mcause and mtval are set; mtval is 0 for interrupts.
  - MPIE ← MIE, then MIE ← 0.
  - `csr_wr_en` is ignored in cycle T.
- mret acceptance: MIE ← MPIE, MPIE ← 1, redirect to mepc.
- Trap target:
  - Exceptions, and all traps when mode is 00: base.
  - Interrupts in vectored mode: base + 4×cause.
- FSM:
  - IDLE → REDIR on trap or mret acceptance.
  - REDIR → IDLE unconditionally.
  - In REDIR, `exc_ena`, `mret_ena` and interrupts are ignored; CSR accesses and counters still operate.

## Timing
- Read path: `csr_rdata` and `csr_illegal` are zero-latency combinational.
- Writes: take effect at the next edge and are visible the following cycle.
- Redirect: accepted in T; `redirect_valid` is high during T+1 only, with `redirect_pc` stable during T+1.
- Back-to-back traps: minimum spacing is 2 cycles, caused by REDIR.
- Interrupt sampling: an `irq_*` edge reaches mip one cycle later, so the earliest interrupt acceptance is 1 cycle after the edge.
- Reset: all CSRs 0 except MPP (reads 11); counters 0; FSM IDLE; all outputs 0. Reset in REDIR aborts the pulse in the next cycle.

## Structure
- Shared package entries:
  - CSR address constants.
  - Cause codes 3/7/11.
  - mstatus/mie bit positions.
  - Mode encodings.
  - FSM state typedef.
- Sub-module `csr_counter`, instanced twice (mcycle, minstret) with parameters CNT_W and INC_W: inhibit, write override, wrap.

## Test plan
- Reset, then read 0x300 → 0x1800. Read 0xF14 with `HART_ID`=3 → 3.
- Write mtvec=0x8000_0001, set mie bit 7 and MIE=1, raise `irq_tmr` with `pc_i`=0x8000_1000 and `commit_valid`=1:
  - → redirect_pc 0x8000_001C.
  - → mcause 0x8000_0000_0000_0007, mepc 0x8000_1000, MIE 0, MPIE 1.
- `exc_ena` with cause 11 together with a pending MEI → mcause 11 and redirect to base. Then `mret` → redirect to mepc, MIE 1.
- `retire_cnt`=2 for 5 cycles → minstret +10. Set IR → minstret frozen while mcycle keeps counting. Write mcycle=0xFFFF…FF → wraps to 0 on the next cycle.
- Write 0xF11 → `csr_illegal`=1, value unchanged. Read 0x7C0 → `csr_illegal`=1, `csr_rdata` 0.
- Trap in T, second `exc_ena` in T+1 → ignored, no second pulse. Assert `rst` during REDIR → `redirect_valid` 0 the next cycle.
